// File: rtl/regfile_arb_pkg.sv
// Shared types for the register-file arbiter: buffered write entries and per-cycle actions.
package regfile_arb_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    ACT_IDLE,
    ACT_READ,
    ACT_DRAIN
  } action_t;

endpackage

// File: rtl/regfile_wr_fifo.sv
// Write buffer for the register-file arbiter; exposes per-entry valid/address for hazard compare.
module regfile_wr_fifo
  import regfile_arb_pkg::*;
#(
  parameter int WB_DEPTH = 4,
  localparam int PTR_W   = $clog2(WB_DEPTH),
  localparam int CNT_W   = PTR_W + 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             push,
  input  logic                             pop,
  input  wb_entry_t                        push_entry,
  output wb_entry_t                        head,
  output logic [CNT_W-1:0]                 count,
  output logic [WB_DEPTH-1:0]              entry_valid,
  output logic [WB_DEPTH-1:0][ADDR_W-1:0]  entry_addr
);

  wb_entry_t        mem [WB_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // NOTE: the storage array has no reset; entry_valid alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      entry_valid <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
      // When full, push and pop hit the same slot, so the push must win.
      for (int i = 0; i < WB_DEPTH; i++) begin
        if (push && PTR_W'(i) == wr_ptr)      entry_valid[i] <= 1'b1;
        else if (pop && PTR_W'(i) == rd_ptr)  entry_valid[i] <= 1'b0;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < WB_DEPTH; i++) entry_addr[i] = mem[i].addr;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/regfile_arbiter.sv
// Sequences reads and buffered writes onto the 2R/1W register file, one action per cycle.
// Optional build macro RFA_ZERO_REG_EN makes register 0 read as zero and ignore writes.
module regfile_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int WB_DEPTH      = 4,
  parameter int MAX_RD_STREAK = 8
) (
  input  logic                       RFA_clk,
  input  logic                       RFA_rst,
  input  logic                       RFA_rd_valid,
  output logic                       RFA_rd_ready,
  input  logic [4:0]                 RFA_rd_addr1,
  input  logic [4:0]                 RFA_rd_addr2,
  output logic                       RFA_rd_data_valid,
  output logic [31:0]                RFA_rd_data1,
  output logic [31:0]                RFA_rd_data2,
  input  logic                       RFA_wr_valid,
  output logic                       RFA_wr_ready,
  input  logic [4:0]                 RFA_wr_addr,
  input  logic [31:0]                RFA_wr_data,
  output logic [$clog2(WB_DEPTH):0]  RFA_wb_count,
  output logic [4:0]                 REG_address1,
  output logic [4:0]                 REG_address2,
  output logic [4:0]                 REG_address_wr,
  output logic                       REG_write_1,
  output logic [31:0]                REG_data_wr_in1,
  input  logic [31:0]                REG_data_out1,
  input  logic [31:0]                REG_data_out2
);

  localparam int CNT_W = $clog2(WB_DEPTH) + 1;
  localparam int STK_W = $clog2(MAX_RD_STREAK + 1);

  logic [CNT_W-1:0]               count;
  logic [WB_DEPTH-1:0]            entry_valid;
  logic [WB_DEPTH-1:0][ADDR_W-1:0] entry_addr;
  wb_entry_t                      head;
  wb_entry_t                      push_entry;
  logic                           push;
  logic                           pop;
  logic                           full;
  logic                           nonempty;
  logic                           hazard;
  logic                           chk1;
  logic                           chk2;
  logic [STK_W-1:0]               streak;
  logic [ADDR_W-1:0]              addr1_q;
  logic [ADDR_W-1:0]              addr2_q;
  action_t                        action;

  regfile_wr_fifo #(.WB_DEPTH(WB_DEPTH)) u_wr_fifo (
    .clk         (RFA_clk),
    .rst         (RFA_rst),
    .push        (push),
    .pop         (pop),
    .push_entry  (push_entry),
    .head        (head),
    .count       (count),
    .entry_valid (entry_valid),
    .entry_addr  (entry_addr)
  );

  assign full       = (count == CNT_W'(WB_DEPTH));
  assign nonempty   = (count != '0);
  assign push_entry = '{addr: RFA_wr_addr, data: RFA_wr_data};

`ifdef RFA_ZERO_REG_EN
  assign chk1 = (RFA_rd_addr1 != '0);
  assign chk2 = (RFA_rd_addr2 != '0);
`else
  assign chk1 = 1'b1;
  assign chk2 = 1'b1;
`endif

  // NOTE: combinational outputs get a default first so no path leaves them unassigned (no latch).
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      if (entry_valid[i] && ((chk1 && entry_addr[i] == RFA_rd_addr1) ||
                             (chk2 && entry_addr[i] == RFA_rd_addr2)))
        hazard = 1'b1;
    end
  end

  always_comb begin
    action = ACT_IDLE;
    if (RFA_rst)                                                action = ACT_IDLE;
    else if (full)                                              action = ACT_DRAIN;
    else if (nonempty && streak == STK_W'(MAX_RD_STREAK))       action = ACT_DRAIN;
    else if (RFA_rd_valid && !hazard)                           action = ACT_READ;
    else if (nonempty)                                          action = ACT_DRAIN;
  end

  assign pop          = (action == ACT_DRAIN);
  assign RFA_rd_ready = (action == ACT_READ);
  // A drain frees a slot this cycle, so a full buffer can still take a write.
  assign RFA_wr_ready = !RFA_rst && (!full || pop);

`ifdef RFA_ZERO_REG_EN
  assign push = RFA_wr_valid && RFA_wr_ready && (RFA_wr_addr != '0);
`else
  assign push = RFA_wr_valid && RFA_wr_ready;
`endif

  assign RFA_wb_count    = count;
  assign REG_write_1     = pop;
  assign REG_address_wr  = pop ? head.addr : '0;
  assign REG_data_wr_in1 = pop ? head.data : '0;
  assign REG_address1    = RFA_rst ? '0 : (action == ACT_READ ? RFA_rd_addr1 : addr1_q);
  assign REG_address2    = RFA_rst ? '0 : (action == ACT_READ ? RFA_rd_addr2 : addr2_q);

  always_ff @(posedge RFA_clk) begin
    if (RFA_rst) begin
      streak            <= '0;
      addr1_q           <= '0;
      addr2_q           <= '0;
      RFA_rd_data_valid <= 1'b0;
    end else begin
      RFA_rd_data_valid <= (action == ACT_READ);
      if (action == ACT_READ) begin
        addr1_q <= RFA_rd_addr1;
        addr2_q <= RFA_rd_addr2;
      end
      if (pop || !nonempty)
        streak <= '0;
      else if (action == ACT_READ && streak != STK_W'(MAX_RD_STREAK))
        streak <= streak + 1'b1;
    end
  end

`ifdef RFA_ZERO_REG_EN
  logic zero1_q;
  logic zero2_q;

  always_ff @(posedge RFA_clk) begin
    if (RFA_rst) begin
      zero1_q <= 1'b0;
      zero2_q <= 1'b0;
    end else if (action == ACT_READ) begin
      zero1_q <= (RFA_rd_addr1 == '0);
      zero2_q <= (RFA_rd_addr2 == '0);
    end
  end

  assign RFA_rd_data1 = zero1_q ? '0 : REG_data_out1;
  assign RFA_rd_data2 = zero2_q ? '0 : REG_data_out2;
`else
  assign RFA_rd_data1 = REG_data_out1;
  assign RFA_rd_data2 = REG_data_out2;
`endif

endmodule
